if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-low (rst=0 sampled at a rising edge resets the block).
REQ-004 stall  input  1  SHALL mean the IF/ID register is not accepting the presented instruction this cycle.
REQ-005 redirect  input  1  SHALL mean a taken branch or jump; redirect_pc  input  32  SHALL be the new fetch address.
REQ-006 imem_req  output  1  SHALL be the instruction-memory request; imem_addr  output  32  SHALL be its word address.
REQ-007 imem_ack  input  1  SHALL mean the response is valid; imem_rdata  input  32  SHALL be the returned instruction.
REQ-008 Instruction_out  output  32, PCplus4_out  output  32, valid_out  output  1 SHALL present the fetched instruction and its PC+4 to the IF/ID register.

Function
REQ-009 The block SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding, result kept) and DROP (request outstanding, result discarded).
REQ-010 imem_req SHALL be 1 exactly in WAIT and DROP; imem_addr SHALL equal the internal pc and SHALL stay stable from request assertion until imem_ack=1 is sampled.
REQ-011 Consumption (fire) SHALL occur in any cycle with valid_out=1 and stall=0.
REQ-012 A one-entry skid register SHALL hold a response that arrives while valid_out=1 and stall=1.
REQ-013 The output register SHALL load, in priority order, skid contents, then the current non-dropped response, whenever valid_out=0 or fire; otherwise it SHALL hold its value.
REQ-014 valid_out SHALL clear after fire when neither the skid register nor a response supplies new data.
REQ-015 PCplus4_out SHALL be (address of the instruction + 4) mod 2^32; wrap-around from 0xFFFF_FFFC to 0x0000_0000 SHALL be silent.
REQ-016 IDLE->WAIT SHALL occur when the skid register is empty and redirect=0.
REQ-017 In WAIT with imem_ack=1, pc SHALL advance by 4.
REQ-018 In WAIT with imem_ack=1, the block SHALL stay in WAIT when the response did not enter the skid register, otherwise go to IDLE; back-to-back acks SHALL give one instruction per cycle.
REQ-019 redirect=1 SHALL have priority over all other events: valid_out and the skid register SHALL clear, and pc SHALL load {redirect_pc[31:2],2'b00}.
REQ-020 redirect=1 in WAIT without imem_ack SHALL move the block to DROP; the old address SHALL stay on imem_addr until the ack, which SHALL be discarded, then the block SHALL go to WAIT at the redirect pc.
REQ-021 redirect=1 with imem_ack=1 in the same cycle SHALL discard that response and go to WAIT at the redirect pc in the next cycle.
REQ-022 redirect=1 in DROP SHALL only update pc; the block SHALL remain in DROP.
REQ-023 stall=1 SHALL never drop or reorder an instruction; program order SHALL be preserved through the skid register.

Reset
REQ-024 On rst=0 at an edge, the block SHALL set state=IDLE, pc=RESET_PC, valid_out=0, Instruction_out=0, PCplus4_out=0, skid empty, imem_req=0.
REQ-025 Reset SHALL override everything, including mid-request (WAIT/DROP); an ack arriving after reset for a pre-reset request is outside the contract (memory is reset together).

Structure
REQ-026 State encodings and the default RESET_PC SHALL live in the shared pipeline definitions include.
REQ-027 The skid register SHALL be one sub-module, if_skid_reg (64-bit data, valid, load/clear/unload); the FSM and pc SHALL stay in if_fetch.

Verification
REQ-028 Reset release, ack every WAIT cycle, rdata FFFF_FFFF/FFFF_0000/8000_0000 at addresses 0/4/8 -> Instruction_out shows these on consecutive cycles with PCplus4_out 4/8/12, valid_out=1.
REQ-029 stall=1 held for 3 cycles while acks continue -> one word goes to skid, imem_req drops, no loss or duplication; after release the order is addr 0,4,8,12.
REQ-030 Request at 0x10 with ack delayed 3 cycles, redirect to 0x100 in cycle 1 -> DROP, imem_addr stays 0x10 until ack, data never reaches valid_out, next imem_addr=0x100, PCplus4_out=0x104.
REQ-031 redirect to 0x40 in the same cycle as ack at 0x8 -> 0x8 data discarded, next imem_addr=0x40.
REQ-032 rst=0 in WAIT with valid_out=1 -> next cycle valid_out=0, imem_req=0, pc=RESET_PC; first post-reset fetch from 0.
REQ-033 redirect_pc=0xFFFF_FFFE -> imem_addr=0xFFFF_FFFC, PCplus4_out=0x0000_0000, next imem_addr=0x0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// default reset PC and the skid-register payload width.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // request outstanding, response will be kept
    ST_DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Skid payload is {PC+4, instruction}.
  localparam int unsigned SKID_W = 64;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry skid register. Priority: clear, then load, then unload.
// Data only changes on load; valid tells whether the entry is occupied.
module if_skid_reg
  import if_fetch_pkg::*;
#(
  parameter int unsigned W = SKID_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state of the single entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: request FSM, fetch PC, output register towards
// IF/ID and a one-entry skid buffer so a stalled consumer never loses data.
//
// Handshake: the IF/ID register consumes the presented word (fire) in any
// cycle where valid_out=1 and stall=0; the memory side holds imem_req and
// imem_addr steady until a cycle with imem_ack=1, whose imem_rdata is the
// answer to that address.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  Instruction_out,
  output logic [31:0]  PCplus4_out,
  output logic         valid_out,
  output fetch_state_e dbg_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;

  logic              fire, out_open, resp_ok, resp_to_skid;
  logic [31:0]       resp_pcp4;
  logic              skid_valid, skid_load, skid_unload, skid_clear;
  logic [SKID_W-1:0] skid_data;

  // Output-register, skid-control and FSM next-state decisions.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    pcp4_d      = pcp4_q;
    valid_d     = valid_q;
    skid_unload = 1'b0;

    fire         = valid_q & ~stall;
    out_open     = ~valid_q | fire;
    // A response is kept only in WAIT and only when no redirect kills it.
    resp_ok      = (state_q == ST_WAIT) & imem_ack & ~redirect;
    resp_pcp4    = addr_q + 32'd4;
    resp_to_skid = resp_ok & ~out_open;
    skid_clear   = redirect;
    skid_load    = resp_to_skid;

    // Skid contents are older than any live response, so they go first.
    if (redirect) begin
      valid_d = 1'b0;
    end else if (out_open) begin
      if (skid_valid) begin
        pcp4_d      = skid_data[63:32];
        instr_d     = skid_data[31:0];
        valid_d     = 1'b1;
        skid_unload = 1'b1;
      end else if (resp_ok) begin
        pcp4_d  = resp_pcp4;
        instr_d = imem_rdata;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!redirect && !skid_valid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ack) begin
          // Once a word is parked in the skid, stop fetching until it drains.
          state_d = resp_to_skid ? ST_IDLE : ST_WAIT;
          pc_d    = pc_q + 32'd4;
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_ack) state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) pc_d = word_align(redirect_pc);

    // The memory address only moves when a new request starts; in DROP it
    // keeps the stale address until that request is acknowledged.
    if (state_d == ST_WAIT) addr_d = pc_d;
    req_d = (state_d != ST_IDLE);
  end

  // FSM, PC and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  if_skid_reg #(.W(SKID_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (skid_clear),
    .load      (skid_load),
    .unload    (skid_unload),
    .load_data ({resp_pcp4, imem_rdata}),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign Instruction_out = instr_q;
  assign PCplus4_out     = pcp4_q;
  assign valid_out       = valid_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory responder, directed scenarios, random traffic,
// and a scoreboard that expects the program-order instruction stream.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          W        = 64;
  localparam int          WINDOW   = 64;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic [31:0]  Instruction_out;
  logic [31:0]  PCplus4_out;
  logic         valid_out;
  fetch_state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .Instruction_out (Instruction_out),
    .PCplus4_out     (PCplus4_out),
    .valid_out       (valid_out),
    .dbg_state       (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_fires  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: a few fixed words at the bottom, a scrambled pattern elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hFFFF_FFFF;
      32'h0000_0004: return 32'hFFFF_0000;
      32'h0000_0008: return 32'h8000_0000;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Program order from a start address: sequential words, wrapping at 2^32.
  task automatic refill(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < WINDOW; i++) begin
      exp_q.push_back({a + 32'd4, mem_fn(a)});
      a = a + 32'd4;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Every consumed word must be the next one in program order; a redirect
  // restarts the order at the aligned target, reset restarts it at RESET_PC.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      refill(RESET_PC);
    end else begin
      if (valid_out && !stall) begin
        n_fires++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", Instruction_out, e[31:0]);
          check("sb_pcplus4", PCplus4_out, e[63:32]);
        end
      end
      if (redirect) refill(redirect_pc & ~32'h3);
    end
  end

  // ---------------- memory responder ----------------
  // mem_mode 0: random latency 0..3, 1: ack every request cycle, 2: ack driven by the stimulus.
  int          mem_mode = 1;
  bit          busy = 1'b0;
  int          lat, cnt;
  logic [31:0] cur_addr;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_mode == 2) begin
        busy = 1'b0;
      end else if (!rst || !imem_req) begin
        imem_ack = 1'b0;
        busy     = 1'b0;
      end else begin
        if (!busy) begin
          busy     = 1'b1;
          cnt      = 0;
          lat      = (mem_mode == 1) ? 0 : $urandom_range(0, 3);
          cur_addr = imem_addr;
          check("imem_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        end else begin
          check("imem_addr_stable", imem_addr, cur_addr);
        end
        if (cnt == lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_fn(imem_addr);
          busy       = 1'b0;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    tick();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr", Instruction_out, 32'd0);
    check("rst_pcplus4", PCplus4_out, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int since_redir;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    repeat (2) tick();

    // Back-to-back acks: one word per cycle with correct PC+4.
    mem_mode = 1;
    do_reset();
    tick();
    check("b2b_req", {31'd0, imem_req}, 32'd1);
    check("b2b_addr0", imem_addr, RESET_PC);
    tick();
    check("b2b_instr0", Instruction_out, 32'hFFFF_FFFF);
    check("b2b_pc4_0", PCplus4_out, 32'd4);
    check("b2b_valid0", {31'd0, valid_out}, 32'd1);
    tick();
    check("b2b_instr1", Instruction_out, 32'hFFFF_0000);
    check("b2b_pc4_1", PCplus4_out, 32'd8);
    tick();
    check("b2b_instr2", Instruction_out, 32'h8000_0000);
    check("b2b_pc4_2", PCplus4_out, 32'd12);
    check("b2b_valid2", {31'd0, valid_out}, 32'd1);

    // Stall for three cycles while a response lands: it must park in the skid.
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    tick();
    check("stall_req_drop", {31'd0, imem_req}, 32'd0);
    check("stall_hold0", Instruction_out, 32'hFFFF_FFFF);
    tick();
    tick();
    check("stall_hold2", Instruction_out, 32'hFFFF_FFFF);
    check("stall_valid", {31'd0, valid_out}, 32'd1);
    stall = 1'b0;
    tick();
    check("skid_instr", Instruction_out, 32'hFFFF_0000);
    check("skid_pc4", PCplus4_out, 32'd8);
    repeat (4) tick();

    // Redirect while a request is outstanding: DROP, stale address held.
    mem_mode = 2;
    imem_ack = 1'b0;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0010;
    tick();
    redirect = 1'b0;
    tick();
    check("drop_req", {31'd0, imem_req}, 32'd1);
    check("drop_addr_start", imem_addr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    check("drop_state", {30'd0, dbg_state}, {30'd0, ST_DROP});
    check("drop_addr_hold1", imem_addr, 32'h10);
    tick();
    check("drop_addr_hold2", imem_addr, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0010;
    tick();
    check("drop_new_addr", imem_addr, 32'h100);
    check("drop_no_valid", {31'd0, valid_out}, 32'd0);
    check("drop_to_wait", {30'd0, dbg_state}, {30'd0, ST_WAIT});
    imem_rdata = mem_fn(32'h100);
    tick();
    check("drop_after_instr", Instruction_out, mem_fn(32'h100));
    check("drop_after_pc4", PCplus4_out, 32'h104);

    // Redirect coinciding with an ack: the acked word is discarded.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0008;
    imem_rdata  = 32'hBAD0_0104;
    tick();
    check("same_addr8", imem_addr, 32'h8);
    redirect_pc = 32'h0000_0040;
    imem_rdata  = mem_fn(32'h8);
    tick();
    check("same_addr40", imem_addr, 32'h40);
    check("same_no_valid", {31'd0, valid_out}, 32'd0);
    redirect = 1'b0;
    imem_ack = 1'b0;
    mem_mode = 1;
    tick();
    check("same_instr40", Instruction_out, mem_fn(32'h40));
    check("same_pc4_40", PCplus4_out, 32'h44);

    // Reset in WAIT with a valid word presented.
    rst = 1'b0;
    tick();
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b1;
    tick();
    check("midrst_first_addr", imem_addr, RESET_PC);
    check("midrst_first_req", {31'd0, imem_req}, 32'd1);

    // Unaligned redirect near the top of memory, then silent wrap.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_instr", Instruction_out, mem_fn(32'hFFFF_FFFC));
    check("wrap_pc4", PCplus4_out, 32'h0000_0000);
    check("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Random traffic: random latency, stalls, redirects and rare resets.
    mem_mode    = 0;
    since_redir = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      stall = ($urandom_range(0, 99) < 35);
      since_redir++;
      if ($urandom_range(0, 99) < 4 || since_redir >= 40) begin
        redirect    = 1'b1;
        since_redir = 0;
        if ($urandom_range(0, 99) < 25) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else                            redirect_pc = $urandom;
      end else begin
        redirect = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) begin
        rst         = 1'b0;
        since_redir = 0;
      end else begin
        rst = 1'b1;
      end
    end

    // Drain.
    stall    = 1'b0;
    redirect = 1'b0;
    rst      = 1'b1;
    repeat (20) tick();
    check("liveness_fires", {31'd0, (n_fires >= 300)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
